// File: rtl/gb_timer.sv
`timescale 1ns/1ps
// gb_timer: Game Boy DIV/TIMA/TMA/TAC timer block.
// A 16-bit system counter advances on each `tick`. TIMA counts falling edges
// of a TAC-selected counter bit, reloads from TMA on overflow, and raises a
// one-clock `irq` on the clock after the overflow.
// Build option: define GB_TIMER_DIV_GLITCH_EN so that falling edges caused by
// DIV or TAC writes also increment TIMA, as on DMG silicon.
module gb_timer #(
   parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tick,
   input  logic [15:0] addr,
   input  logic        wr,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        hit,
   output logic        irq
);

   // register offsets from BASE_ADDR
   localparam logic [1:0] OFF_DIV  = 2'd0;
   localparam logic [1:0] OFF_TIMA = 2'd1;
   localparam logic [1:0] OFF_TMA  = 2'd2;
   localparam logic [1:0] OFF_TAC  = 2'd3;

   logic [15:0] sys_cnt;
   logic [7:0]  tima;
   logic [7:0]  tma;
   logic [2:0]  tac;
   logic        sel_prev;
   logic        ovf_pend;

   logic [15:0] offset;
   logic        wr_div, wr_tima, wr_tma, wr_tac;
   logic [15:0] cnt_nxt;
   logic [2:0]  tac_nxt;
   logic        bit_nxt;
   logic        sel_nxt;
   logic        fall;
   logic        inc;
   logic        ovf;

   // Modular subtraction keeps the range test correct for any BASE_ADDR:
   // addresses below the base wrap to large offsets and miss.
   assign offset = addr - BASE_ADDR;
   assign hit    = (offset[15:2] == 14'd0);

   assign wr_div  = wr & hit & (offset[1:0] == OFF_DIV);
   assign wr_tima = wr & hit & (offset[1:0] == OFF_TIMA);
   assign wr_tma  = wr & hit & (offset[1:0] == OFF_TMA);
   assign wr_tac  = wr & hit & (offset[1:0] == OFF_TAC);

   // next system counter: a DIV write beats a same-cycle tick
   always_comb begin
      cnt_nxt = sys_cnt;
      if (wr_div)
         cnt_nxt = 16'h0000;
      else if (tick)
         cnt_nxt = sys_cnt + 16'd1;
   end

   assign tac_nxt = wr_tac ? din[2:0] : tac;

   // selected bit, taken from the post-update counter and TAC so the tick
   // that clears the bit bumps TIMA on that same edge
   always_comb begin
      bit_nxt = 1'b0;
      unique case (tac_nxt[1:0])
         2'b00: bit_nxt = cnt_nxt[9];
         2'b01: bit_nxt = cnt_nxt[3];
         2'b10: bit_nxt = cnt_nxt[5];
         2'b11: bit_nxt = cnt_nxt[7];
      endcase
   end

   assign sel_nxt = tac_nxt[2] & bit_nxt;

   // sel_prev always holds the sel of the current register state
   assign fall = sel_prev & ~sel_nxt;

`ifdef GB_TIMER_DIV_GLITCH_EN
   // any falling edge counts, including ones produced by DIV/TAC writes
   assign inc = fall;
`else
   // write-induced edges are swallowed; sel_prev still reloads post-write
   assign inc = fall & ~(wr_div | wr_tac);
`endif

   // a TIMA write in the same clock overrides the increment and the overflow
   assign ovf = inc & (tima == 8'hFF) & ~wr_tima;

   // counter, TAC and edge-tracking state
   always_ff @(posedge clock) begin
      if (reset) begin
         sys_cnt  <= 16'h0000;
         tac      <= 3'b000;
         sel_prev <= 1'b0;
         ovf_pend <= 1'b0;
      end else begin
         sys_cnt  <= cnt_nxt;
         tac      <= tac_nxt;
         sel_prev <= sel_nxt;
         ovf_pend <= ovf;
      end
   end

   // TIMA/TMA: reload uses the pre-write TMA even if TMA is written now
   always_ff @(posedge clock) begin
      if (reset) begin
         tima <= 8'h00;
         tma  <= 8'h00;
      end else begin
         if (wr_tma)
            tma <= din;
         if (wr_tima)
            tima <= din;
         else if (ovf)
            tima <= tma;
         else if (inc)
            tima <= tima + 8'd1;
      end
   end

   // ovf_pend is a flop that self-clears, so irq is a registered one-clock pulse
   assign irq = ovf_pend;

   // read mux; unmapped addresses float high like an open bus
   always_comb begin
      dout = 8'hFF;
      if (hit) begin
         unique case (offset[1:0])
            OFF_DIV:  dout = sys_cnt[15:8];
            OFF_TIMA: dout = tima;
            OFF_TMA:  dout = tma;
            OFF_TAC:  dout = {5'b11111, tac};
         endcase
      end
   end

endmodule

// File: tb/tb_gb_timer.sv
`timescale 1ns/1ps
// tb_gb_timer: directed scenarios plus randomized traffic against a
// period-based reference model of the timer.
module tb_gb_timer;

   localparam logic [15:0] BASE = 16'hFF04;

`ifdef GB_TIMER_DIV_GLITCH_EN
   localparam bit GLITCH = 1'b1;
`else
   localparam bit GLITCH = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        tick  = 1'b0;
   logic [15:0] addr  = 16'h0000;
   logic        wr    = 1'b0;
   logic [7:0]  din   = 8'h00;
   logic [7:0]  dout;
   logic        hit;
   logic        irq;

   int tests_run = 0;
   int failed    = 0;

   // reference model state
   logic [15:0] m_cnt;
   logic [7:0]  m_tima, m_tma;
   logic [2:0]  m_tac;
   logic        m_irq;

   gb_timer #(.BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset), .tick(tick), .addr(addr),
      .wr(wr), .din(din), .dout(dout), .hit(hit), .irq(irq)
   );

   always #5 clock = ~clock;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: run did not finish (tests=%0d)", tests_run);
      $fatal(1, "watchdog");
   end

   // timer input level: enabled and in the upper half of its period
   function automatic bit m_sel(input logic [15:0] cnt, input logic [2:0] t);
      int p;
      case (t[1:0])
         2'd0:    p = 1024;
         2'd1:    p = 16;
         2'd2:    p = 64;
         default: p = 256;
      endcase
      return t[2] && ((int'(cnt) % p) >= p / 2);
   endfunction

   function automatic void m_update(input bit r, input bit t, input bit w,
                                    input logic [15:0] a, input logic [7:0] d);
      logic [15:0] o;
      logic [15:0] ncnt;
      logic [2:0]  ntac;
      logic [7:0]  ntima;
      bit map, wdiv, wtac, edge_hit;
      if (r) begin
         m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_irq = 0;
         return;
      end
      o    = a - BASE;
      map  = w && (o < 16'd4);
      wdiv = map && o == 16'd0;
      wtac = map && o == 16'd3;
      ncnt = wdiv ? 16'h0000 : (t ? m_cnt + 16'd1 : m_cnt);
      ntac = wtac ? d[2:0] : m_tac;
      edge_hit = m_sel(m_cnt, m_tac) && !m_sel(ncnt, ntac);
      if (!GLITCH && (wdiv || wtac)) edge_hit = 0;
      m_irq = 0;
      ntima = m_tima;
      if (edge_hit) begin
         if (m_tima == 8'hFF) begin ntima = m_tma; m_irq = 1; end
         else ntima = m_tima + 8'd1;
      end
      if (map && o == 16'd1) begin ntima = d; m_irq = 0; end
      if (map && o == 16'd2) m_tma = d;
      m_cnt = ncnt; m_tac = ntac; m_tima = ntima;
   endfunction

   function automatic logic [8:0] m_read(input logic [15:0] a);
      logic [15:0] o;
      o = a - BASE;
      if (o >= 16'd4) return {1'b0, 8'hFF};
      case (o[1:0])
         2'd0:    return {1'b1, m_cnt[15:8]};
         2'd1:    return {1'b1, m_tima};
         2'd2:    return {1'b1, m_tma};
         default: return {1'b1, 5'b11111, m_tac};
      endcase
   endfunction

   // one clock with the given inputs; ends 1ns after the edge
   task automatic step(input bit r, input bit t, input bit w,
                       input logic [15:0] a, input logic [7:0] d);
      reset = r; tick = t; wr = w; addr = a; din = d;
      @(posedge clock);
      m_update(r, t, w, a, d);
      #1;
      reset = 0; tick = 0; wr = 0;
   endtask

   task automatic wreg(input int off, input logic [7:0] d);
      step(0, 0, 1, BASE + 16'(off), d);
   endtask

   task automatic ticks(input int n);
      repeat (n) step(0, 1, 0, 16'h0000, 8'h00);
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic h);
      addr = a; wr = 0;
      #1;
      d = dout; h = hit;
   endtask

   task automatic test_reset;
      logic [7:0] d; logic h;
      step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
      tests_run++;
      if (irq !== 1'b0) begin failed++; $display("FAIL reset_irq got=%b exp=0", irq); end
      rd(BASE, d, h);
      tests_run++;
      if (d !== 8'h00 || h !== 1'b1) begin failed++; $display("FAIL reset_div got=%h/%b exp=00/1", d, h); end
      rd(BASE + 1, d, h);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL reset_tima got=%h exp=00", d); end
      rd(BASE + 2, d, h);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL reset_tma got=%h exp=00", d); end
      rd(BASE + 3, d, h);
      tests_run++;
      if (d !== 8'hF8) begin failed++; $display("FAIL reset_tac got=%h exp=f8", d); end
   endtask

   task automatic test_count_reload;
      logic [7:0] d; logic h;
      int n_irq, at;
      n_irq = 0; at = -1;
      step(1, 0, 0, 0, 0);
      wreg(3, 8'h05); wreg(2, 8'h80); wreg(1, 8'hFE);
      for (int i = 1; i <= 32; i++) begin
         step(0, 1, 0, 0, 0);
         if (irq === 1'b1) begin n_irq++; at = i; end
      end
      step(0, 0, 0, 0, 0);
      if (irq === 1'b1) n_irq++;
      tests_run++;
      if (n_irq != 1 || at != 32) begin failed++; $display("FAIL reload_irq count=%0d at=%0d exp=1 at 32", n_irq, at); end
      rd(BASE + 1, d, h);
      tests_run++;
      if (d !== 8'h80) begin failed++; $display("FAIL reload_tima got=%h exp=80", d); end
   endtask

   task automatic test_div;
      logic [7:0] d; logic h;
      step(1, 0, 0, 0, 0);
      ticks(256);
      rd(BASE, d, h);
      tests_run++;
      if (d !== 8'h01) begin failed++; $display("FAIL div_256 got=%h exp=01", d); end
      ticks(65280);
      rd(BASE, d, h);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL div_wrap got=%h exp=00", d); end
      ticks(700);
      rd(BASE, d, h);
      tests_run++;
      if (d !== 8'h02) begin failed++; $display("FAIL div_700 got=%h exp=02", d); end
      wreg(0, 8'h5A);
      rd(BASE, d, h);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL div_write got=%h exp=00", d); end
   endtask

   task automatic test_glitch;
      logic [7:0] d; logic h;
      logic [7:0] exp1;
      exp1 = GLITCH ? 8'h01 : 8'h00;
      step(1, 0, 0, 0, 0);
      wreg(3, 8'h04);
      ticks(512);
      rd(BASE + 1, d, h);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL glitch_pre got=%h exp=00", d); end
      wreg(0, 8'h00);
      rd(BASE + 1, d, h);
      tests_run++;
      if (d !== exp1) begin failed++; $display("FAIL glitch_div got=%h exp=%h", d, exp1); end
      // disabling the timer while the selected bit is high
      step(1, 0, 0, 0, 0);
      wreg(3, 8'h05);
      ticks(8);
      wreg(3, 8'h01);
      rd(BASE + 1, d, h);
      tests_run++;
      if (d !== exp1) begin failed++; $display("FAIL glitch_tac got=%h exp=%h", d, exp1); end
   endtask

   task automatic test_collisions;
      logic [7:0] d; logic h;
      bit seen;
      step(1, 0, 0, 0, 0);
      wreg(3, 8'h05); wreg(1, 8'hFF);
      ticks(15);
      step(0, 1, 1, BASE + 1, 8'h10);
      seen = (irq === 1'b1);
      step(0, 0, 0, 0, 0);
      seen = seen || (irq === 1'b1);
      tests_run++;
      if (seen) begin failed++; $display("FAIL coll_tima_irq got=1 exp=0"); end
      rd(BASE + 1, d, h);
      tests_run++;
      if (d !== 8'h10) begin failed++; $display("FAIL coll_tima got=%h exp=10", d); end

      step(1, 0, 0, 0, 0);
      wreg(3, 8'h05); wreg(2, 8'h20); wreg(1, 8'hFF);
      ticks(15);
      step(0, 1, 1, BASE + 2, 8'h40);
      tests_run++;
      if (irq !== 1'b1) begin failed++; $display("FAIL coll_tma_irq got=%b exp=1", irq); end
      rd(BASE + 1, d, h);
      tests_run++;
      if (d !== 8'h20) begin failed++; $display("FAIL coll_tma_tima got=%h exp=20", d); end
      rd(BASE + 2, d, h);
      tests_run++;
      if (d !== 8'h40) begin failed++; $display("FAIL coll_tma_tma got=%h exp=40", d); end
   endtask

   task automatic test_bus;
      logic [7:0] d; logic h;
      step(1, 0, 0, 0, 0);
      wreg(3, 8'hFF);
      rd(BASE + 3, d, h);
      tests_run++;
      if (d !== 8'hFF) begin failed++; $display("FAIL bus_tac_ff got=%h exp=ff", d); end
      wreg(3, 8'h02);
      rd(BASE + 3, d, h);
      tests_run++;
      if (d !== 8'hFA) begin failed++; $display("FAIL bus_tac_02 got=%h exp=fa", d); end
      rd(16'hFF08, d, h);
      tests_run++;
      if (d !== 8'hFF || h !== 1'b0) begin failed++; $display("FAIL bus_ff08 got=%h/%b exp=ff/0", d, h); end
      rd(16'hFF03, d, h);
      tests_run++;
      if (d !== 8'hFF || h !== 1'b0) begin failed++; $display("FAIL bus_ff03 got=%h/%b exp=ff/0", d, h); end
      wreg(2, 8'hC3);
      rd(BASE + 2, d, h);
      tests_run++;
      if (d !== 8'hC3 || h !== 1'b1) begin failed++; $display("FAIL bus_tma got=%h/%b exp=c3/1", d, h); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] d; logic h;
      bit seen;
      step(1, 0, 0, 0, 0);
      wreg(3, 8'h05); wreg(2, 8'h33); wreg(1, 8'hFF);
      ticks(15);
      step(1, 1, 0, 0, 0);
      seen = (irq === 1'b1);
      step(0, 0, 0, 0, 0);
      seen = seen || (irq === 1'b1);
      tests_run++;
      if (seen) begin failed++; $display("FAIL rstmid_irq got=1 exp=0"); end
      rd(BASE, d, h);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL rstmid_div got=%h exp=00", d); end
      rd(BASE + 1, d, h);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL rstmid_tima got=%h exp=00", d); end
      rd(BASE + 2, d, h);
      tests_run++;
      if (d !== 8'h00) begin failed++; $display("FAIL rstmid_tma got=%h exp=00", d); end
      rd(BASE + 3, d, h);
      tests_run++;
      if (d !== 8'hF8) begin failed++; $display("FAIL rstmid_tac got=%h exp=f8", d); end
   endtask

   task automatic test_random;
      logic [7:0] d; logic h;
      logic [8:0] e;
      logic [15:0] a, ra;
      logic [7:0] wd;
      bit r, t, w;
      int n_irq;
      n_irq = 0;
      step(1, 0, 0, 0, 0);
      wreg(3, 8'h05);
      for (int i = 0; i < 2500; i++) begin
         r  = ($urandom_range(0, 499) == 0);
         t  = ($urandom_range(0, 3) != 0);
         w  = ($urandom_range(0, 15) == 0);
         a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 3));
         wd = 8'($urandom);
         if (a == BASE + 1) wd = wd | 8'hF0;
         step(r, t, w, a, wd);
         if (m_irq) n_irq++;
         tests_run++;
         if (irq !== m_irq) begin failed++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, irq, m_irq); end
         ra = 16'hFF02 + 16'($urandom_range(0, 7));
         rd(ra, d, h);
         e = m_read(ra);
         tests_run++;
         if ({h, d} !== e) begin failed++; $display("FAIL rand_rd cyc=%0d addr=%h got=%b/%h exp=%b/%h", i, ra, h, d, e[8], e[7:0]); end
      end
      tests_run++;
      if (n_irq == 0) begin failed++; $display("FAIL rand_coverage overflows=%0d exp>0", n_irq); end
   endtask

   initial begin
      test_reset;
      test_count_reload;
      test_div;
      test_glitch;
      test_collisions;
      test_bus;
      test_reset_mid;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule

// File: doc/gb_timer.md
# gb_timer

Game Boy DIV/TIMA/TMA/TAC timer block, the consumer of the divider's one-cycle `enable` strobe. A 16-bit system counter advances once per tick. TIMA counts falling edges of a selected counter bit. On TIMA overflow, TIMA reloads from TMA and the block raises a one-cycle timer interrupt request toward the interrupt controller.

## Interface
- `BASE_ADDR`, default 16'hFF04: address of DIV. TIMA, TMA and TAC sit at +1, +2 and +3.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle enable from the divider at the 4.194304 MHz machine rate. Held low during reset.
- `addr`  in  16  CPU bus address.
- `wr`  in  1  write strobe, one cycle per write.
- `din`  in  8  write data.
- `dout`  out  8  read data. Combinational from `addr` and the register state.
- `hit`  out  1  high when `addr` is in BASE_ADDR..BASE_ADDR+3.
- `irq`  out  1  timer interrupt request, one-cycle pulse.

## Operation
- State:
  - `sys_cnt` [15:0]
  - `tima`, `tma` [7:0]
  - `tac` [2:0]
  - `sel_prev` [0]
  - `ovf_pend` [0]
- System counter:
  - `sys_cnt` increments by 1 on each tick and wraps from 16'hFFFF to 0.
  - DIV reads `sys_cnt[15:8]`.
  - A write to DIV (any data) clears `sys_cnt` to 0. The write wins over a same-cycle tick.
- Selected bit, chosen by TAC[1:0]:
  - 00 → `sys_cnt[9]`
  - 01 → `sys_cnt[3]`
  - 10 → `sys_cnt[5]`
  - 11 → `sys_cnt[7]`
- `sel` = TAC[2] & selected bit.
- `sel_prev` loads `sel` every clock.
- Falling edge: `sel_prev`=1 and `sel`=0. Each falling edge increments TIMA by 1, mod 256.
- Overflow (TIMA at 8'hFF when incremented):
  - TIMA <= current TMA in the same clock.
  - `ovf_pend` <= 1.
  - The TMA value used is the pre-write value, even if TMA is written in the same cycle.
- `irq` = `ovf_pend`, registered. It is high exactly one clock, the clock after the overflow. `ovf_pend` self-clears.
- Register writes: `wr` with a mapped `addr` loads `din`.
  - A TIMA write in the same clock as an increment: the written value wins, no overflow, no irq.
  - A TAC write stores `din[2:0]` only.
- Reads, with `hit` high:
  - DIV → `sys_cnt[15:8]`
  - TIMA → `tima`
  - TMA → `tma`
  - TAC → {5'b11111, `tac`}
- Unmapped `addr`: `dout` = 8'hFF, `hit` = 0.

## Timing
- Reset values:
  - `sys_cnt`=0, `tima`=0, `tma`=0, `tac`=0
  - `sel_prev`=0, `ovf_pend`=0, `irq`=0
  - `dout` at DIV address = 8'h00
- Reset mid-count clears all state in the same clock. No irq fires for an overflow coincident with reset.
- Increment latency:
  - The tick that clears the selected bit updates TIMA on that clock edge.
  - The new TIMA value is visible on `dout` the next cycle.
- Write latency: a register written on clock N reads back its new value from cycle N+1.
- TIMA increment period with TAC[2]=1, in ticks:
  - 00 → 1024
  - 01 → 16
  - 10 → 64
  - 11 → 256
- Back-to-back overflows are not possible: the minimum gap is 16 ticks. `irq` never stays high for 2 consecutive clocks.

## Configuration
- `GB_TIMER_DIV_GLITCH_EN` defined: falling edges of `sel` caused by DIV writes or TAC writes (enable clear or select change) increment TIMA, matching DMG hardware.
- `GB_TIMER_DIV_GLITCH_EN` undefined:
  - In a cycle with a DIV or TAC write, `sel_prev` is reloaded with the post-write `sel`.
  - No increment occurs from the write.
  - Only tick-driven falling edges count.

## Test plan
- Counting and reload:
  - Setup: reset; TAC=0x05; TMA=0x80; TIMA=0xFE.
  - Stimulus: 32 ticks.
  - Required: TIMA=0x80; `irq` high exactly one clock, one cycle after the 32nd-tick edge.
- DIV:
  - 256 ticks from reset → DIV reads 0x01.
  - A further 65280 ticks → DIV reads 0x00 (wrap).
  - Write DIV=0x5A → DIV reads 0x00.
- Glitch:
  - Setup: TAC=0x04; 512 ticks, so `sys_cnt[9]`=1.
  - Stimulus: write DIV.
  - Required: TIMA 0x00→0x01 with `GB_TIMER_DIV_GLITCH_EN`; TIMA stays 0x00 without it.
- Write collisions:
  - TIMA=0xFF, TAC=0x05; write TIMA=0x10 on the overflowing tick → TIMA=0x10, no `irq`.
  - Overflow with TMA=0x20 and a same-cycle TMA write of 0x40 → TIMA=0x20, TMA=0x40.
- Bus:
  - Read TAC after writing 0xFF → 0xFF.
  - Read TAC after writing 0x02 → 0xFA.
  - Read 16'hFF08 → `dout`=0xFF, `hit`=0.
- Reset mid-operation: assert `reset` on the overflow tick → all registers 0, no `irq` pulse afterward.
